// File: rtl/demux_buf.sv
// demux_buf: registered 1-to-8 demultiplexer with a single-entry holding
// register and valid/ready handshakes on both the upstream and the
// per-channel downstream sides.
module demux_buf #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [7:0]       xfer_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] hold_data;
  logic [2:0]       hold_sel;
  logic             in_hs;
  logic             out_hs;

  // Handshake decode; only the addressed channel's ready is considered,
  // and in_ready is independent of in_valid.
  always_comb begin
    in_ready = 1'b1;
    out_hs   = 1'b0;
    if (state == FULL) begin
      in_ready = out_ready[hold_sel];
      out_hs   = out_ready[hold_sel];
    end
    in_hs = in_valid & in_ready;
  end

  // Next-state logic; a simultaneous drain and refill stays FULL.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (in_hs) state_next = FULL;
      FULL:    if (out_hs && !in_hs) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Holding register, loaded only on an accepted input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      hold_sel  <= '0;
    end else if (in_hs) begin
      hold_data <= in_data;
      hold_sel  <= in_sel;
    end
  end

  // Completed output transfer counter, wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         xfer_count <= '0;
    else if (out_hs) xfer_count <= xfer_count + 8'd1;
  end

  // Output presentation: one-hot valid and held data only while FULL.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    if (state == FULL) begin
      out_valid = 8'h01 << hold_sel;
      out_data  = hold_data;
    end
  end

endmodule

// File: tb/tb_demux_buf.sv
// Directed bench for demux_buf (WIDTH=8): a vector table checked one cycle
// at a time, plus hand-written hold, async-reset and counter-wrap sequences.
module tb_demux_buf;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic [7:0] xfer_count;

  int unsigned n_checks;
  int unsigned n_fail;

  demux_buf #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [2:0] sel;
    logic [7:0] d;
    logic [7:0] ordy;
    logic [7:0] e_ov;
    logic [7:0] e_od;
    logic       e_ir;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic row(input logic r, input logic iv, input logic [2:0] sel, input logic [7:0] d,
                     input logic [7:0] ordy, input logic [7:0] e_ov, input logic [7:0] e_od,
                     input logic e_ir, input logic [7:0] e_cnt);
    vec_t v;
    v.rst = r; v.iv = iv; v.sel = sel; v.d = d; v.ordy = ordy;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic [7:0] ov, input logic [7:0] od,
                            input logic ir, input logic [7:0] cnt);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".out_data"}, 32'(out_data), 32'(od));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
    check({tag, ".xfer_count"}, 32'(xfer_count), 32'(cnt));
  endtask

  // Drive at the falling edge, sample 1 time unit later (well before the rising edge).
  task automatic drive(input logic r, input logic iv, input logic [2:0] sel,
                       input logic [7:0] d, input logic [7:0] ordy);
    @(negedge clk);
    rst = r; in_valid = iv; in_sel = sel; in_data = d; out_ready = ordy;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;

    // Outputs observed before the next rising edge: state reflects prior edges.
    //   rst iv sel data  ordy   ov     od     ir  cnt
    row(0, 1, 5, 8'h01, 8'h00, 8'h00, 8'h00, 1, 8'd0);  // accept sel5
    row(0, 0, 0, 8'h00, 8'h00, 8'h20, 8'h01, 0, 8'd0);  // held
    row(0, 1, 3, 8'h55, 8'hDF, 8'h20, 8'h01, 0, 8'd0);  // other readys ignored
    row(0, 0, 0, 8'h00, 8'h20, 8'h20, 8'h01, 1, 8'd0);  // drain
    row(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'd1);
    row(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'd0);  // reset
    row(0, 1, 0, 8'hA0, 8'hFF, 8'h00, 8'h00, 1, 8'd0);  // stream starts
    row(0, 1, 1, 8'hA1, 8'hFF, 8'h01, 8'hA0, 1, 8'd0);
    row(0, 1, 2, 8'hA2, 8'hFF, 8'h02, 8'hA1, 1, 8'd1);
    row(0, 1, 3, 8'hA3, 8'hFF, 8'h04, 8'hA2, 1, 8'd2);
    row(0, 1, 4, 8'hA4, 8'hFF, 8'h08, 8'hA3, 1, 8'd3);
    row(0, 1, 5, 8'hA5, 8'hFF, 8'h10, 8'hA4, 1, 8'd4);
    row(0, 1, 6, 8'hA6, 8'hFF, 8'h20, 8'hA5, 1, 8'd5);
    row(0, 1, 7, 8'hA7, 8'hFF, 8'h40, 8'hA6, 1, 8'd6);
    row(0, 0, 0, 8'h00, 8'hFF, 8'h80, 8'hA7, 1, 8'd7);
    row(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'd8);  // stream done
    row(0, 1, 2, 8'hC2, 8'h00, 8'h00, 8'h00, 1, 8'd8);  // load sel2
    row(0, 1, 7, 8'hE7, 8'h04, 8'h04, 8'hC2, 1, 8'd8);  // drain + refill
    row(0, 0, 0, 8'h00, 8'h00, 8'h80, 8'hE7, 0, 8'd9);
    row(0, 1, 0, 8'h11, 8'h7F, 8'h80, 8'hE7, 0, 8'd9);  // no overwrite
    row(0, 0, 0, 8'h00, 8'h00, 8'h80, 8'hE7, 0, 8'd9);

    // Reset values while rst is held.
    @(negedge clk);
    #1;
    check_outs("reset", 8'h00, 8'h00, 1'b1, 8'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].d, vecs[i].ordy);
      check_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir, vecs[i].e_cnt);
    end

    // Async reset mid-cycle while FULL (sel7/E7 held from the table).
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 8'h00, 8'h00, 1'b1, 8'd0);
    drive(0, 0, 0, 8'h00, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 8'h00, 8'hFF);
      check_outs($sformatf("post_rst%0d", i), 8'h00, 8'h00, 1'b1, 8'd0);
    end

    // Long hold with no ready, then non-addressed readys, then drain.
    drive(0, 1, 5, 8'h01, 8'h00);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 8'h00, 8'h00);
      check_outs($sformatf("hold%0d", i), 8'h20, 8'h01, 1'b0, 8'd0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 8'h77, 8'hDF);
      check_outs($sformatf("hold_df%0d", i), 8'h20, 8'h01, 1'b0, 8'd0);
    end
    drive(0, 0, 0, 8'h00, 8'h20);
    drive(0, 0, 0, 8'h00, 8'h00);
    check_outs("drain5", 8'h00, 8'h00, 1'b1, 8'd1);

    // Counter wrap: 259 completed transfers from reset.
    drive(1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 259; i++) begin
      drive(0, 1, 3'(i % 8), 8'(i), 8'hFF);
      if (i == 256) check("wrap_mid.xfer_count", 32'(xfer_count), 32'd255);
    end
    drive(0, 0, 0, 8'h00, 8'hFF);
    check("wrap_last.out_data", 32'(out_data), 32'd2);
    drive(0, 0, 0, 8'h00, 8'h00);
    check_outs("wrap", 8'h00, 8'h00, 1'b1, 8'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_buf.md
DEMUX_BUF -- requirements
Module: demux_buf

Interface
REQ-001 Parameter: WIDTH, default 1, data width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_data  input  WIDTH  payload from upstream.
REQ-005 Port: in_sel  input  3  destination channel index, 0..7.
REQ-006 Port: in_valid  input  1  upstream offers in_data/in_sel.
REQ-007 Port: in_ready  output  1  block accepts this cycle.
REQ-008 Port: out_data  output  WIDTH  held payload, shared by all 8 channels.
REQ-009 Port: out_valid  output  8  one-hot, bit k = payload pending for channel k.
REQ-010 Port: out_ready  input  8  bit k = channel k consumes this cycle.
REQ-011 Port: xfer_count  output  8  count of completed output transfers.

Function
REQ-012 Block SHALL be a registered 1-to-8 demultiplexer with a single-entry holding register and valid/ready handshake on both sides.
REQ-013 State machine SHALL have two states: EMPTY (no held entry) and FULL (one held entry).
REQ-014 Input handshake SHALL complete on a rising edge when in_valid=1 and in_ready=1; in_data and in_sel are captured into hold_data/hold_sel.
REQ-015 Output handshake SHALL complete on a rising edge when FULL and out_ready[hold_sel]=1.
REQ-016 out_ready bits other than out_ready[hold_sel] SHALL be ignored.
REQ-017 in_ready SHALL be 1 in EMPTY; in FULL, in_ready SHALL equal out_ready[hold_sel] (drain and refill in the same cycle).
REQ-018 Transitions: EMPTY->FULL on input handshake; FULL->EMPTY on output handshake without input handshake; FULL->FULL with new data/sel on simultaneous input and output handshakes; otherwise hold state.
REQ-019 Latency: data accepted at edge N SHALL appear on out_data with out_valid[sel] asserted from edge N to edge N+1 and onward; one-cycle minimum latency, no combinational in-to-out path.
REQ-020 In FULL, out_valid SHALL be exactly one-hot at bit hold_sel; in EMPTY, out_valid SHALL be 8'h00.
REQ-021 out_data SHALL equal hold_data in FULL and all-zeros in EMPTY.
REQ-022 Held entry SHALL remain stable (data, sel, valid) until its output handshake; no drop, no overwrite while FULL without drain.
REQ-023 in_ready SHALL NOT depend on in_valid.
REQ-024 in_sel, in_data SHALL be don't-care when in_valid=0.
REQ-025 xfer_count SHALL increment by 1 on each output handshake, unsigned, wrapping 8'hFF->8'h00.
REQ-026 Back-to-back throughput SHALL be one transfer per cycle when the addressed out_ready is held high.

Reset
REQ-027 rst=1 SHALL immediately (asynchronously) force state EMPTY, hold_data=0, hold_sel=0, xfer_count=0, out_valid=8'h00, out_data=0, in_ready=1 after release.
REQ-028 Reset asserted while FULL SHALL discard the held entry with no output handshake and no count increment.
REQ-029 First input handshake SHALL be possible on the first rising edge with rst=0.

Verification
REQ-030 Reset then in_valid=1, in_sel=5, in_data=1 one cycle, out_ready=8'h00 -> next cycle out_valid=8'h20, out_data=1, in_ready=0, held for 10 cycles unchanged.
REQ-031 From REQ-030 state, out_ready=8'hDF (all except bit 5) -> no drain, xfer_count=0; then out_ready=8'h20 -> one edge later out_valid=8'h00, xfer_count=1.
REQ-032 WIDTH=8, out_ready=8'hFF, stream sel=0..7 with data 8'hA0..8'hA7 on consecutive cycles -> in_ready constantly 1, out_valid walks 8'h01..8'h80, data matches, xfer_count=8.
REQ-033 FULL with sel=2, out_ready[2]=1 and new in_valid sel=7 same cycle -> next cycle out_valid=8'h80 with new data, state FULL, xfer_count +1.
REQ-034 259 transfers completed -> xfer_count=8'h03 (wrap).
REQ-035 Assert rst mid-cycle while FULL (asynchronous to clk) -> out_valid=8'h00 and xfer_count=0 before next edge; entry not re-presented after release.
